data_pipe_serializer: RTL and testbench

Parametrised N-lane to 1-lane serializer, next generation of the N-to-1 data pipe. Accepts a full N-lane word with a per-lane keep mask and a packet-last flag, and emits only the kept lanes, one per beat, in a configurable lane order. Sits between wide datapath stages and narrow stream consumers. Sustains one output beat per cycle with registered backpressure on both sides.

---
 rtl/data_pipe_pkg.sv | 30 +++
 rtl/data_pipe_fifo.sv | 58 +++++
 rtl/data_pipe_skid.sv | 50 +++++
 rtl/data_pipe_serializer.sv | 126 ++++++++++++
 tb/tb_data_pipe_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_pipe_pkg.sv
// Shared helpers for the N-lane to 1-lane data pipe serializer.
//   lane_w   : bit width needed to index NSIZE lanes (at least 1)
//   sel_lane : index of the lowest (or highest) set bit of a lane mask
//   MAX_LANES: widest lane mask the helpers accept
// The buffer entry struct {data, keep, last} depends on DSIZE/NSIZE, so it
// is declared inside the top module where those widths are known.
package data_pipe_pkg;

  localparam int MAX_LANES = 128;

  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mask bits at or above n must be zero; the caller zero-extends.
  function automatic int sel_lane(input logic [MAX_LANES-1:0] mask,
                                  input int n, input logic msb_first);
    int lane;
    lane = 0;
    if (msb_first) begin
      for (int i = 0; i < MAX_LANES; i++)
        if (i < n && mask[i]) lane = i;
    end else begin
      for (int i = MAX_LANES - 1; i >= 0; i--)
        if (i < n && mask[i]) lane = i;
    end
    return lane;
  endfunction

endpackage

// File: rtl/data_pipe_fifo.sv
// First-word-fall-through word buffer.
//   wr_data/wr_vld/wr_ready : push side; wr_ready is a register, low in reset
//   rd_data/rd_vld          : head entry, valid whenever not empty
//   rd_pop                  : remove head (ignored when empty)
module data_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_nxt;
  logic             push, pop;

  assign push    = wr_vld && wr_ready;
  assign pop     = rd_pop && rd_vld;
  assign rd_vld  = (count != '0);
  assign rd_data = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // Ready is computed from the next occupancy so it is a clean register
  // output and drops the cycle after the buffer fills.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_nxt;
      wr_ready <= (count_nxt < CW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/data_pipe_skid.sv
// Two-entry registered valid/ready slice.
//   in_data/in_vld/in_ready    : upstream; in_ready is high when fewer than
//                                two entries are held or one leaves this cycle
//   out_data/out_vld/out_ready : downstream; out_data/out_vld are registers
module data_pipe_skid #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_ready
);

  logic [WIDTH-1:0] hold_data_p1;
  logic             hold_vld_p1;
  logic             take, give;

  // hold_vld_p1 implies out_vld, so "not full" reduces to !hold_vld_p1.
  assign give     = out_vld && out_ready;
  assign in_ready = !hold_vld_p1 || give;
  assign take     = in_vld && in_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_vld      <= 1'b0;
      hold_data_p1 <= '0;
      hold_vld_p1  <= 1'b0;
    end else if (give || !out_vld) begin
      // output register free: refill from hold entry first to keep order
      if (hold_vld_p1) begin
        out_data    <= hold_data_p1;
        out_vld     <= 1'b1;
        hold_vld_p1 <= take;
        if (take) hold_data_p1 <= in_data;
      end else begin
        out_vld <= take;
        if (take) out_data <= in_data;
      end
    end else if (take) begin
      hold_data_p1 <= in_data;
      hold_vld_p1  <= 1'b1;
    end
  end

endmodule

// File: rtl/data_pipe_serializer.sv
// N-lane to 1-lane serializer: emits only the kept lanes of each buffered
// word, one per beat, lowest lane first (MSB_FIRST=0) or highest first.
//   clock, rst_n                      : clock, asynchronous active-low reset
//   wr_data/wr_keep/wr_last/wr_vld    : input word, keep mask, packet end
//   wr_ready                          : word buffer not full (registered)
//   rd_data/rd_last/rd_vld/rd_ready   : output lane stream (registered)
//   err_nokeep                        : pulse, keep==0 word with last dropped
//   busy                              : anything buffered or in flight
module data_pipe_serializer
  import data_pipe_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NSIZE     = 8,
  parameter int IN_DEPTH  = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [DSIZE*NSIZE-1:0] wr_data,
  input  logic [NSIZE-1:0]       wr_keep,
  input  logic                   wr_last,
  input  logic                   wr_vld,
  output logic                   wr_ready,
  output logic [DSIZE-1:0]       rd_data,
  output logic                   rd_last,
  output logic                   rd_vld,
  input  logic                   rd_ready,
  output logic                   err_nokeep,
  output logic                   busy
);

  localparam int RSIZE = lane_w(NSIZE);
  localparam int EW    = DSIZE*NSIZE + NSIZE + 1;

  typedef struct packed {
    logic                   last;
    logic [NSIZE-1:0]       keep;
    logic [DSIZE*NSIZE-1:0] data;
  } entry_t;

  entry_t wr_entry, head;
  logic   head_vld, head_pop;

  assign wr_entry = '{last: wr_last, keep: wr_keep, data: wr_data};

  data_pipe_fifo #(
    .WIDTH (EW),
    .DEPTH (IN_DEPTH)
  ) u_word_buf (
    .clock    (clock),
    .rst_n    (rst_n),
    .wr_data  (wr_entry),
    .wr_vld   (wr_vld),
    .wr_ready (wr_ready),
    .rd_data  (head),
    .rd_vld   (head_vld),
    .rd_pop   (head_pop)
  );

  // ---- stage p0: lane selection from buffer head ----
  logic [NSIZE-1:0]     rem, cur_mask, nxt_mask;
  logic                 fresh;
  logic [MAX_LANES-1:0] mask_ext;
  logic [RSIZE-1:0]     lane;
  logic                 issue_p0, word_done, drop_zero, skid_ready;
  logic [DSIZE-1:0]     iss_data_p0;
  logic                 iss_last_p0;

  always_comb begin
    // A fresh head has not issued anything yet, so its keep mask is the
    // remaining set; afterwards rem tracks the lanes still to send.
    cur_mask  = fresh ? head.keep : rem;
    mask_ext  = '0;
    mask_ext[NSIZE-1:0] = cur_mask;
    lane      = RSIZE'(sel_lane(mask_ext, NSIZE, MSB_FIRST != 0));
    nxt_mask  = cur_mask & ~(NSIZE'(1) << lane);
    // An empty-keep word is dropped without waiting on the output stage.
    drop_zero = head_vld && (cur_mask == '0);
    issue_p0  = head_vld && (cur_mask != '0) && skid_ready;
    word_done = issue_p0 && (nxt_mask == '0);
    head_pop  = drop_zero || word_done;
    iss_data_p0 = head.data[DSIZE*lane +: DSIZE];
    iss_last_p0 = head.last && word_done;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      fresh      <= 1'b1;
      err_nokeep <= 1'b0;
    end else begin
      err_nokeep <= drop_zero && head.last;
      if (head_pop) begin
        fresh <= 1'b1;
      end else if (issue_p0) begin
        fresh <= 1'b0;
        rem   <= nxt_mask;
      end
    end
  end

  // ---- stage p1: registered output skid ----
  logic [DSIZE:0] skid_in, skid_out;

  assign skid_in = {iss_last_p0, iss_data_p0};

  data_pipe_skid #(
    .WIDTH (DSIZE + 1)
  ) u_out_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_data   (skid_in),
    .in_vld    (issue_p0),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_vld   (rd_vld),
    .out_ready (rd_ready)
  );

  assign rd_last = skid_out[DSIZE];
  assign rd_data = skid_out[DSIZE-1:0];

  // The skid hold entry is only occupied while rd_vld is high.
  assign busy = head_vld || rd_vld;

endmodule

// File: tb/tb_data_pipe_serializer.sv
module tb_data_pipe_serializer;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_keep = '0;
  logic        wr_last = 1'b0;
  logic        wr_vld = 1'b0;
  logic        rd_ready = 1'b0;

  logic        wr_ready0, rd_last0, rd_vld0, err0, busy0;
  logic [7:0]  rd_data0;
  logic        wr_ready1, rd_last1, rd_vld1, err1, busy1;
  logic [7:0]  rd_data1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_cnt = 0;
  int stab_bad = 0;

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [31:0] c;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  always #5 clock = ~clock;

  data_pipe_serializer #(.DSIZE(8), .NSIZE(4), .IN_DEPTH(4), .MSB_FIRST(0)) dut0 (
    .clock(clock), .rst_n(rst_n), .wr_data(wr_data), .wr_keep(wr_keep),
    .wr_last(wr_last), .wr_vld(wr_vld), .wr_ready(wr_ready0), .rd_data(rd_data0),
    .rd_last(rd_last0), .rd_vld(rd_vld0), .rd_ready(rd_ready), .err_nokeep(err0),
    .busy(busy0));

  data_pipe_serializer #(.DSIZE(8), .NSIZE(4), .IN_DEPTH(4), .MSB_FIRST(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .wr_data(wr_data), .wr_keep(wr_keep),
    .wr_last(wr_last), .wr_vld(wr_vld), .wr_ready(wr_ready1), .rd_data(rd_data1),
    .rd_last(rd_last1), .rd_vld(rd_vld1), .rd_ready(rd_ready), .err_nokeep(err1),
    .busy(busy1));

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: records every transfer (tagged with the edge it happens
  // on), counts err_nokeep high cycles and flags data changing while stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_l = 1'b0;
  always @(negedge clock) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_vld0 && rd_ready) q0.push_back('{d: rd_data0, l: rd_last0, c: cyc + 1});
      if (rd_vld1 && rd_ready) q1.push_back('{d: rd_data1, l: rd_last1, c: cyc + 1});
      if (err0) err_cnt++;
      if (prev_stall && (!rd_vld0 || rd_data0 !== prev_d || rd_last0 !== prev_l)) stab_bad++;
      prev_stall = rd_vld0 && !rd_ready;
      prev_d = rd_data0;
      prev_l = rd_last0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    int guard;
    wr_data = d; wr_keep = k; wr_last = l; wr_vld = 1'b1;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 200) begin
      acc = wr_ready0;
      step();
      guard++;
    end
    wr_vld = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance", d);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((busy0 || busy1) && guard < 2000) begin
      step();
      guard++;
    end
    step();
    checks++;
    if (busy0 || busy1) begin
      failures++;
      $display("FAIL drain_timeout: busy0=%0b busy1=%0b required 0", busy0, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (wr_ready0 !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready0); end
    checks++; if (rd_vld0 !== 1'b0) begin failures++; $display("FAIL rst_rd_vld: got %b want 0", rd_vld0); end
    checks++; if (rd_data0 !== 8'h00) begin failures++; $display("FAIL rst_rd_data: got %h want 00", rd_data0); end
    checks++; if (rd_last0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL rst_flags: last=%b err=%b busy=%b want 0 0 0", rd_last0, err0, busy0);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (wr_ready0 !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", wr_ready0); end
  endtask

  task automatic test_lsb_full();
    beat_t exp[$];
    int t;
    q0.delete(); q1.delete();
    rd_ready = 1'b1;
    send_word(32'h44332211, 4'b1111, 1'b1);
    t = cyc;
    exp = '{'{d: 8'h11, l: 1'b0, c: t + 2}, '{d: 8'h22, l: 1'b0, c: t + 3},
            '{d: 8'h33, l: 1'b0, c: t + 4}, '{d: 8'h44, l: 1'b1, c: t + 5}};
    wait_drain();
    checks++; if (q0.size() != exp.size()) begin failures++; $display("FAIL lsb_count: got %0d want %0d", q0.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== exp[i]) begin
        failures++;
        $display("FAIL lsb_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d", i,
                 q0[i].d, q0[i].l, q0[i].c, exp[i].d, exp[i].l, exp[i].c);
      end
    end
  endtask

  task automatic test_msb_first();
    beat_t exp1[$];
    beat_t exp0[$];
    int t;
    q0.delete(); q1.delete();
    rd_ready = 1'b1;
    send_word(32'h44332211, 4'b1010, 1'b1);
    t = cyc;
    exp1 = '{'{d: 8'h44, l: 1'b0, c: t + 2}, '{d: 8'h22, l: 1'b1, c: t + 3}};
    exp0 = '{'{d: 8'h22, l: 1'b0, c: t + 2}, '{d: 8'h44, l: 1'b1, c: t + 3}};
    wait_drain();
    checks++; if (q1.size() != 2 || q0.size() != 2) begin
      failures++; $display("FAIL msb_count: got %0d/%0d want 2/2", q1.size(), q0.size());
    end
    for (int i = 0; i < 2 && i < q1.size() && i < q0.size(); i++) begin
      checks++;
      if (q1[i] !== exp1[i] || q0[i] !== exp0[i]) begin
        failures++;
        $display("FAIL msb_beat%0d: got msb d=%h l=%b c=%0d lsb d=%h want msb d=%h l=%b c=%0d lsb d=%h", i,
                 q1[i].d, q1[i].l, q1[i].c, q0[i].d, exp1[i].d, exp1[i].l, exp1[i].c, exp0[i].d);
      end
    end
  endtask

  task automatic test_nokeep();
    logic [7:0] exp_d[8] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    int base;
    q0.delete(); q1.delete();
    rd_ready = 1'b1;
    base = err_cnt;
    send_word(32'hA4A3A2A1, 4'b1111, 1'b1);
    send_word(32'hDEADBEEF, 4'b0000, 1'b1);
    send_word(32'hB4B3B2B1, 4'b1111, 1'b1);
    wait_drain();
    checks++; if (err_cnt - base != 1) begin failures++; $display("FAIL nokeep_err_cycles: got %0d want 1", err_cnt - base); end
    checks++; if (q0.size() != 8) begin failures++; $display("FAIL nokeep_count: got %0d want 8", q0.size()); end
    for (int i = 0; i < 8 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].d !== exp_d[i] || q0[i].l !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL nokeep_beat%0d: got d=%h l=%b want d=%h l=%b", i, q0[i].d, q0[i].l, exp_d[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    int base;
    bit acc;
    logic [7:0] ed;
    q0.delete(); q1.delete();
    base = stab_bad;
    rd_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      wr_data = {16'h0000, 8'(n_acc * 16 + 2), 8'(n_acc * 16 + 1)};
      wr_keep = 4'b0011;
      wr_last = n_acc[0];
      wr_vld = 1'b1;
      acc = wr_ready0;
      step();
      if (acc) n_acc++;
    end
    wr_vld = 1'b0;
    checks++; if (n_acc != 5) begin failures++; $display("FAIL bp_accepted: got %0d want 5", n_acc); end
    checks++; if (wr_ready0 !== 1'b0) begin failures++; $display("FAIL bp_wr_ready: got %b want 0", wr_ready0); end
    checks++; if (q0.size() != 0 || rd_vld0 !== 1'b1) begin
      failures++; $display("FAIL bp_stalled: beats=%0d rd_vld=%b want 0 and 1", q0.size(), rd_vld0);
    end
    rd_ready = 1'b1;
    wait_drain();
    checks++; if (stab_bad != base) begin failures++; $display("FAIL bp_stable: got %0d changes want 0", stab_bad - base); end
    checks++; if (q0.size() != 10) begin failures++; $display("FAIL bp_count: got %0d want 10", q0.size()); end
    for (int i = 0; i < 10 && i < q0.size(); i++) begin
      ed = 8'((i / 2) * 16 + (i % 2) + 1);
      checks++;
      if (q0[i].d !== ed || q0[i].l !== ((i % 2 == 1) && ((i / 2) % 2 == 1))) begin
        failures++;
        $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", i, q0[i].d, q0[i].l, ed,
                 ((i % 2 == 1) && ((i / 2) % 2 == 1)));
      end
    end
  endtask

  task automatic test_random();
    beat_t exp0[$];
    beat_t exp1[$];
    int base_err, base_stab, exp_err, exp_lasts, got_lasts, bad0, bad1;
    bit done;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    q0.delete(); q1.delete();
    base_err = err_cnt; base_stab = stab_bad;
    exp_err = 0; exp_lasts = 0; done = 1'b0;
    fork
      begin
        for (int w = 0; w < 30; w++) begin
          d = $urandom;
          k = 4'($urandom_range(0, 15));
          l = 1'($urandom_range(0, 1));
          if (l && k == 4'b0000) exp_err++;
          if (l && k != 4'b0000) exp_lasts++;
          for (int j = 0; j < 4; j++)
            if (k[j]) exp0.push_back('{d: d[8*j +: 8], l: l && ((k >> (j + 1)) == 4'b0000), c: 0});
          for (int j = 3; j >= 0; j--)
            if (k[j]) exp1.push_back('{d: d[8*j +: 8], l: l && ((k & 4'((1 << j) - 1)) == 4'b0000), c: 0});
          send_word(d, k, l);
        end
        done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while (!done && g < 5000) begin
          rd_ready = 1'($urandom_range(0, 1));
          step();
          g++;
        end
      end
    join
    rd_ready = 1'b1;
    wait_drain();
    got_lasts = 0;
    foreach (q0[i]) if (q0[i].l) got_lasts++;
    checks++; if (q0.size() != exp0.size() || q1.size() != exp1.size()) begin
      failures++; $display("FAIL rand_count: got %0d/%0d want %0d/%0d", q0.size(), q1.size(), exp0.size(), exp1.size());
    end
    bad0 = -1; bad1 = -1;
    for (int i = 0; i < exp0.size() && i < q0.size(); i++)
      if (bad0 < 0 && (q0[i].d !== exp0[i].d || q0[i].l !== exp0[i].l)) bad0 = i;
    for (int i = 0; i < exp1.size() && i < q1.size(); i++)
      if (bad1 < 0 && (q1[i].d !== exp1[i].d || q1[i].l !== exp1[i].l)) bad1 = i;
    checks++; if (bad0 >= 0) begin
      failures++; $display("FAIL rand_lsb_order: beat %0d got d=%h l=%b want d=%h l=%b", bad0,
                           q0[bad0].d, q0[bad0].l, exp0[bad0].d, exp0[bad0].l);
    end
    checks++; if (bad1 >= 0) begin
      failures++; $display("FAIL rand_msb_order: beat %0d got d=%h l=%b want d=%h l=%b", bad1,
                           q1[bad1].d, q1[bad1].l, exp1[bad1].d, exp1[bad1].l);
    end
    checks++; if (got_lasts != exp_lasts) begin failures++; $display("FAIL rand_lasts: got %0d want %0d", got_lasts, exp_lasts); end
    checks++; if (err_cnt - base_err != exp_err) begin failures++; $display("FAIL rand_err: got %0d want %0d", err_cnt - base_err, exp_err); end
    checks++; if (stab_bad != base_stab) begin failures++; $display("FAIL rand_stable: got %0d changes want 0", stab_bad - base_stab); end
  endtask

  task automatic test_reset_mid();
    q0.delete(); q1.delete();
    rd_ready = 1'b0;
    send_word(32'h55667788, 4'b1111, 1'b1);
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clock);
    checks++; if (rd_vld0 !== 1'b0 || rd_last0 !== 1'b0 || rd_data0 !== 8'h00) begin
      failures++; $display("FAIL midrst_out: vld=%b last=%b data=%h want 0 0 00", rd_vld0, rd_last0, rd_data0);
    end
    checks++; if (busy0 !== 1'b0 || wr_ready0 !== 1'b0 || err0 !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl: busy=%b wr_ready=%b err=%b want 0 0 0", busy0, wr_ready0, err0);
    end
    step();
    rst_n = 1'b1;
    step();
    rd_ready = 1'b1;
    send_word(32'h0D0C0B0A, 4'b0101, 1'b1);
    wait_drain();
    checks++; if (q0.size() != 2) begin failures++; $display("FAIL midrst_count: got %0d want 2", q0.size()); end
    else begin
      checks++;
      if (q0[0].d !== 8'h0A || q0[0].l !== 1'b0 || q0[1].d !== 8'h0C || q0[1].l !== 1'b1) begin
        failures++;
        $display("FAIL midrst_beats: got %h/%b %h/%b want 0a/0 0c/1", q0[0].d, q0[0].l, q0[1].d, q0[1].l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_full();
    test_msb_first();
    test_nokeep();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
